// File: rtl/mux4_scan_pkg.sv
// Shared types and constants for the mux4 scan sequencer.
package mux4_scan_pkg;

  localparam int SEL_W  = 2;
  localparam int DATA_W = 4;

  localparam logic [SEL_W-1:0] SEL_FIRST_ASC  = 2'd0;
  localparam logic [SEL_W-1:0] SEL_FIRST_DESC = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Starting select for a scan in the given direction (0 = ascending).
  function automatic logic [SEL_W-1:0] sel_first(input logic dir);
    return dir ? SEL_FIRST_DESC : SEL_FIRST_ASC;
  endfunction

  // Next select in the given direction; wraps modulo 4 by width.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] sel,
                                                input logic             dir);
    return dir ? (sel - 1'b1) : (sel + 1'b1);
  endfunction

endpackage

// File: rtl/mux4_scan_seq_hold_timer.sv
// Hold-period counter: expires on the last of HOLD_CYCLES enabled cycles.
module hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expire = (r_cnt == LAST);

  // Count enabled cycles, restarting after each expiry or on clear.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_expire ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux4x1_data.sv
// 4:1 single-bit mux driven by the scan sequencer.
module mux4x1_data (
  input  logic [3:0] i,
  input  logic [1:0] sel,
  output logic       out
);

  // Purely combinational bit select.
  always_comb begin
    out = i[sel];
  end

endmodule

// File: rtl/mux4_scan_seq.sv
// Scan sequencer: accepts a 4-bit word, walks the mux select through all
// four positions and streams the sampled mux output as serial bits.
module mux4_scan_seq
  import mux4_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dir,
  output logic [DATA_W-1:0] mux_i,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              bit_valid,
  output logic              bit_data,
  output logic [SEL_W-1:0]  bit_idx,
  output logic              done
);

  if (HOLD_CYCLES < 1) begin : g_hold_check
    $error("mux4_scan_seq: HOLD_CYCLES must be >= 1");
  end

  state_t     r_state;
  logic       r_dir;
  logic [1:0] r_bit_cnt;
  logic       w_accept;
  logic       w_drive;
  logic       w_expire;

  assign in_ready = (r_state == IDLE) && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_drive  = (r_state == DRIVE);

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (w_accept),
    .i_en     (w_drive),
    .o_expire (w_expire)
  );

  // Accept a word, then sample one bit per hold period until four are out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dir     <= 1'b0;
      r_bit_cnt <= '0;
      mux_i     <= '0;
      mux_sel   <= '0;
      bit_valid <= 1'b0;
      bit_data  <= 1'b0;
      bit_idx   <= '0;
      done      <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      done      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            mux_i     <= in_data;
            r_dir     <= in_dir;
            mux_sel   <= sel_first(in_dir);
            r_bit_cnt <= '0;
            r_state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (w_expire) begin
            bit_data  <= mux_out;
            bit_idx   <= mux_sel;
            bit_valid <= 1'b1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            // Four steps bring the select back to its start value.
            mux_sel   <= sel_step(mux_sel, r_dir);
            if (r_bit_cnt == 2'd3) begin
              done    <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // End of word is always marked on a bit strobe.
  a_done_with_valid: assert property (@(posedge clk) disable iff (rst)
    done |-> bit_valid);

  // No word is taken while a scan is in progress.
  a_no_accept_in_drive: assert property (@(posedge clk) disable iff (rst)
    w_drive |-> !in_ready);

endmodule

// File: doc/mux4_scan_seq.md
# mux4_scan_seq

Upstream sequencer for the 4:1 vector mux (`mux4x1_data`). It accepts a 4-bit word over a valid/ready handshake and drives the mux's `i` and `sel` inputs. It then steps `sel` through all four positions in a latched direction, holding each select for a programmable number of cycles. On the last cycle of each hold it samples the mux's combinational `out` and emits the resulting serial bit stream with a valid strobe, the bit index, and an end-of-word pulse.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: cycles each select value is held before sampling. Must be ≥1; 0 is an elaboration error.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  a word is offered.
- `in_ready`  out  1  the block can accept a word; equals `(state==IDLE) && !rst`.
- `in_data`  in  4  word to scan; driven onto `mux_i` on accept.
- `in_dir`  in  1  scan direction, latched on accept: 0 = sel 0→3, 1 = sel 3→0.
- `mux_i`  out  4  registered; connects to mux data input.
- `mux_sel`  out  2  registered; connects to mux select.
- `mux_out`  in  1  combinational mux output.
- `bit_valid`  out  1  one-cycle strobe marking a sampled bit.
- `bit_data`  out  1  sampled `mux_out`.
- `bit_idx`  out  2  select value that produced `bit_data`.
- `done`  out  1  one-cycle pulse, coincident with the 4th `bit_valid`.

## Operation
- States:
  - IDLE: `in_ready` is high.
  - DRIVE: scanning is in progress.
- Accept: on an edge with `in_valid && in_ready`, the block:
  - loads `mux_i <= in_data` and latches `in_dir`;
  - sets `mux_sel` to 0 (dir 0) or 3 (dir 1);
  - sets `hold_cnt <= 0` and `bit_cnt <= 0`;
  - moves to DRIVE.
- DRIVE, every edge: if `hold_cnt != HOLD_CYCLES-1`, the block increments `hold_cnt`. Otherwise it samples:
  - `bit_data <= mux_out`, `bit_idx <= mux_sel`, `bit_valid <= 1`;
  - `hold_cnt <= 0`, `bit_cnt++`;
  - `mux_sel` steps ±1 (mod 4) according to the latched direction.
- On the sample where `bit_cnt == 3`, the block also sets `done <= 1` and returns to IDLE. `mux_sel` wraps to the start value; `mux_i` holds its last word.
- `bit_valid` and `done` are low on every edge that is not a sampling edge.
- While `in_ready` is low, `in_valid`, `in_data` and `in_dir` are ignored. Changes to `in_dir` after accept have no effect.
- `hold_cnt` width is `max(1, $clog2(HOLD_CYCLES))`. `bit_cnt` is 2 bits.
- Reset values: `mux_i=0`, `mux_sel=0`, `bit_valid=0`, `bit_data=0`, `bit_idx=0`, `done=0`, state IDLE.
- Reset mid-scan aborts immediately. The word is discarded, no further `bit_valid` or `done` is produced, and `in_ready` is high in the first cycle after `rst` deasserts.

## Timing
- Let E0 be the accept edge. Sampling edges are E0+k·HOLD_CYCLES for k=1..4. Each `bit_valid` is visible in the cycle following its sampling edge.
- `mux_sel` is stable for exactly HOLD_CYCLES cycles per position. The sample is taken at the end of the last hold cycle, so the combinational mux has ≥1 full cycle to settle.
- `done` and the 4th `bit_valid` share the same cycle, and `in_ready` is already high in that cycle. The next word can be accepted at the edge ending that cycle.
- Per-word latency is 4·HOLD_CYCLES cycles from accept to the last bit. Throughput is one word per 4·HOLD_CYCLES+1 cycles.

## Structure
- The shared package `mux4_scan_pkg` holds:
  - the state enum (IDLE, DRIVE);
  - `SEL_FIRST_ASC = 2'd0` and `SEL_FIRST_DESC = 2'd3`;
  - `SEL_W = 2` and `DATA_W = 4`.
- Sub-module `hold_timer` (counter of HOLD_CYCLES with `expire` output and sync clear) is natural. Everything else lives in the top.
- The bench instantiates `mux4x1_data` alongside and wires `mux_i`/`mux_sel`/`mux_out`.

## Test plan
- HOLD=1, `in_data=4'b1010`, dir=0:
  - `bit_idx` 0,1,2,3 and `bit_data` 0,1,0,1 on 4 consecutive cycles;
  - first valid one cycle after accept;
  - `done` with idx 3.
- HOLD=1, `in_data=4'b1100`, dir=1: `bit_idx` 3,2,1,0 with `bit_data` 1,1,0,0; `done` with idx 0.
- HOLD=3, `in_data=4'b0110`, dir=0:
  - `bit_valid` every 3rd cycle, first 3 cycles after accept;
  - bits 0,1,1,0;
  - `mux_sel` constant for 3 cycles each.
- Back-to-back with backpressure: `in_valid` held high with 4'b1111 during a 4'b0001 scan.
  - The second word is not accepted until the `done` cycle.
  - It is accepted at that cycle's ending edge.
  - The 4'b0001 bits are unaffected; `in_dir` toggled mid-scan has no effect.
- Reset after the 2nd `bit_valid` of 4'b1001, HOLD=1:
  - all outputs return to reset values the cycle after the `rst` edge;
  - no further `bit_valid` or `done`;
  - a new word is accepted the first cycle after release.
- Randomized: 6 random words, dirs, HOLD=2. A scoreboard checks each `bit_data == in_data[bit_idx]` and exactly one `done` per word.
